// File: rtl/cpu_clock_gen.sv
// cpu_clock_gen: derives the 8-bit CPU clock from the system clock.
// The CPU clock free-runs with a programmable phase length, or advances one
// debounced pushbutton press at a time in manual mode. HLT holds it low.
// All outputs are registered so cpu_clk is glitch-free and full-phase.
module cpu_clock_gen #(
  parameter int DIV_WIDTH       = 16,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int STEP_HIGH       = 2
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic                 manual_mode,
  input  logic                 step_btn,
  input  logic                 halt,
  output logic                 cpu_clk,
  output logic                 cpu_clk_n,
  output logic                 cpu_clk_rise
);

  // Debounce counter only has to reach DEBOUNCE_CYCLES, then it saturates.
  localparam int                   DB_WIDTH  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_WIDTH-1:0]  DB_TARGET = DB_WIDTH'(DEBOUNCE_CYCLES);
  localparam logic [DB_WIDTH-1:0]  DB_ONE    = DB_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] STEP_LAST = DIV_WIDTH'(STEP_HIGH - 1);
  localparam logic [DIV_WIDTH-1:0] CNT_ONE   = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {
    LOW  = 2'd0,
    HIGH = 2'd1,
    STEP = 2'd2
  } state_t;

  logic [1:0]           mode_sync;
  logic [1:0]           btn_sync;
  logic                 mode_s;
  logic                 btn_s;

  logic                 btn_last;
  logic                 btn_db;
  logic [DB_WIDTH-1:0]  db_cnt;
  logic [DB_WIDTH-1:0]  db_cnt_next;
  logic                 level_accept;
  logic                 press_accept;

  logic                 step_armed;
  logic                 step_take;

  state_t               state;
  state_t               state_next;
  logic [DIV_WIDTH-1:0] cnt;
  logic [DIV_WIDTH-1:0] cnt_next;

  assign mode_s = mode_sync[1];
  assign btn_s  = btn_sync[1];

  // Two-flop synchronizers for the asynchronous switch and pushbutton.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      mode_sync <= 2'b00;
      btn_sync  <= 2'b00;
    end else begin
      mode_sync <= {mode_sync[0], manual_mode};
      btn_sync  <= {btn_sync[0], step_btn};
    end
  end

  // Length of the current run of identical synced samples, including this one.
  always_comb begin
    db_cnt_next = db_cnt;
    if (btn_s != btn_last) begin
      db_cnt_next = DB_ONE;
    end else if (db_cnt < DB_TARGET) begin
      db_cnt_next = db_cnt + DB_ONE;
    end
    level_accept = (db_cnt_next >= DB_TARGET) && (btn_s != btn_db);
    press_accept = level_accept && btn_s;
  end

  // Debounce state: last sample, run length and the accepted button level.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      btn_last <= 1'b0;
      db_cnt   <= '0;
      btn_db   <= 1'b0;
    end else begin
      btn_last <= btn_s;
      db_cnt   <= db_cnt_next;
      if (level_accept) begin
        btn_db <= btn_s;
      end
    end
  end

  // One pending step per accepted press; HLT throws pending presses away.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      step_armed <= 1'b0;
    end else if (halt) begin
      step_armed <= 1'b0;
    end else if (press_accept) begin
      step_armed <= 1'b1;
    end else if (step_take) begin
      step_armed <= 1'b0;
    end
  end

  // Phase sequencing: >= compares let a lowered div end the phase at once.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    step_take  = 1'b0;
    case (state)
      LOW: begin
        if (!halt && !mode_s && (cnt >= div)) begin
          state_next = HIGH;
          cnt_next   = '0;
        end else if (!halt && mode_s && step_armed) begin
          state_next = STEP;
          cnt_next   = '0;
          step_take  = 1'b1;
        end else if (cnt != CNT_MAX) begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      HIGH: begin
        if (cnt >= div) begin
          state_next = LOW;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      STEP: begin
        if (cnt >= STEP_LAST) begin
          state_next = LOW;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      default: begin
        state_next = LOW;
        cnt_next   = '0;
      end
    endcase
  end

  // State, phase counter and the registered clock outputs move together.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state        <= LOW;
      cnt          <= '0;
      cpu_clk      <= 1'b0;
      cpu_clk_n    <= 1'b1;
      cpu_clk_rise <= 1'b0;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      cpu_clk      <= (state_next != LOW);
      cpu_clk_n    <= (state_next == LOW);
      cpu_clk_rise <= (state == LOW) && (state_next != LOW);
    end
  end

endmodule

// File: tb/tb_cpu_clock_gen.sv
// tb_cpu_clock_gen: directed stimulus for cpu_clock_gen with a cycle model
// of the CPU clock rules and hand-computed expectations for each scenario.
module tb_cpu_clock_gen;

  localparam int DW  = 16;
  localparam int DEB = 4;
  localparam int SH  = 2;

  logic          clk = 1'b0;
  logic          clr = 1'b0;
  logic [DW-1:0] div = 16'd3;
  logic          manual_mode = 1'b0;
  logic          step_btn = 1'b0;
  logic          halt = 1'b0;
  logic          cpu_clk;
  logic          cpu_clk_n;
  logic          cpu_clk_rise;

  int check_count = 0;
  int pass_count  = 0;

  int q_mode[$];
  int q_btn[$];
  int q_sync[$];
  bit m_high = 1'b0;
  bit m_step = 1'b0;
  bit m_rise = 1'b0;
  bit m_armed = 1'b0;
  bit m_accepted = 1'b0;
  int m_elapsed = 0;
  int m_sync_mode;
  int m_sync_btn;
  bit m_all_same;
  bit m_new_press;
  bit m_take;
  int m_limit;

  int h;
  int r;
  bit found;

  cpu_clock_gen #(
    .DIV_WIDTH(DW),
    .DEBOUNCE_CYCLES(DEB),
    .STEP_HIGH(SH)
  ) dut (
    .clk(clk),
    .clr(clr),
    .div(div),
    .manual_mode(manual_mode),
    .step_btn(step_btn),
    .halt(halt),
    .cpu_clk(cpu_clk),
    .cpu_clk_n(cpu_clk_n),
    .cpu_clk_rise(cpu_clk_rise)
  );

  // System clock, 10 time units per period.
  always #5 clk = ~clk;

  task automatic check_output(input string name, input int actual, input int expected);
    check_count++;
    if (actual == expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s at t=%0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  // Counts high cycles and rise strobes over n cycles, sampling after each negedge.
  task automatic measure(input int n, output int highs, output int rises);
    highs = 0;
    rises = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      highs += int'(cpu_clk);
      rises += int'(cpu_clk_rise);
    end
  endtask

  // Plays a per-cycle button pattern (bit i = cycle i) while counting pulses.
  task automatic apply_stimulus(input logic [63:0] pattern, input int n,
                                output int highs, output int rises);
    highs = 0;
    rises = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      highs += int'(cpu_clk);
      rises += int'(cpu_clk_rise);
      #1;
      step_btn = pattern[i];
    end
  endtask

  // Waits a bounded number of cycles for a rise strobe.
  task automatic wait_rise(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (cpu_clk_rise) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  // Reference model: inputs delayed two edges, a button level is accepted when
  // the last DEB synced samples agree, and phases follow the length rules.
  always @(posedge clk or posedge clr) begin
    if (clr) begin
      q_mode.delete();
      q_btn.delete();
      q_sync.delete();
      m_high     = 1'b0;
      m_step     = 1'b0;
      m_rise     = 1'b0;
      m_armed    = 1'b0;
      m_accepted = 1'b0;
      m_elapsed  = 0;
    end else begin
      q_mode.push_front(int'(manual_mode));
      q_btn.push_front(int'(step_btn));
      m_sync_mode = (q_mode.size() >= 3) ? q_mode[2] : 0;
      m_sync_btn  = (q_btn.size() >= 3) ? q_btn[2] : 0;
      if (q_mode.size() > 3) void'(q_mode.pop_back());
      if (q_btn.size() > 3) void'(q_btn.pop_back());
      q_sync.push_front(m_sync_btn);
      if (q_sync.size() > DEB) void'(q_sync.pop_back());

      m_new_press = 1'b0;
      if (q_sync.size() == DEB) begin
        m_all_same = 1'b1;
        for (int i = 1; i < q_sync.size(); i++) begin
          if (q_sync[i] != q_sync[0]) m_all_same = 1'b0;
        end
        if (m_all_same && (q_sync[0] != int'(m_accepted))) begin
          m_accepted  = (q_sync[0] != 0);
          m_new_press = m_accepted;
        end
      end

      m_rise = 1'b0;
      m_take = 1'b0;
      if (m_high) begin
        m_limit = m_step ? (SH - 1) : int'(div);
        if (m_elapsed >= m_limit) begin
          m_high    = 1'b0;
          m_elapsed = 0;
        end else begin
          m_elapsed++;
        end
      end else if (!halt && (m_sync_mode == 0) && (m_elapsed >= int'(div))) begin
        m_high    = 1'b1;
        m_step    = 1'b0;
        m_rise    = 1'b1;
        m_elapsed = 0;
      end else if (!halt && (m_sync_mode == 1) && m_armed) begin
        m_high    = 1'b1;
        m_step    = 1'b1;
        m_rise    = 1'b1;
        m_elapsed = 0;
        m_take    = 1'b1;
      end else if (m_elapsed < 65535) begin
        m_elapsed++;
      end

      if (halt) m_armed = 1'b0;
      else if (m_new_press) m_armed = 1'b1;
      else if (m_take) m_armed = 1'b0;
    end
  end

  // Every cycle the three outputs must match the model.
  always @(negedge clk) begin
    check_output("cycle_model", int'({cpu_clk, cpu_clk_n, cpu_clk_rise}),
                 int'({m_high, ~m_high, m_rise}));
  end

  // Directed scenario sequence.
  initial begin
    #1 clr = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_output("reset_cpu_clk", int'(cpu_clk), 0);
    check_output("reset_cpu_clk_n", int'(cpu_clk_n), 1);
    check_output("reset_rise", int'(cpu_clk_rise), 0);
    #1 clr = 1'b0;

    // Run mode div=3: full low phase first, then 4 high / 4 low.
    measure(3, h, r);
    check_output("first_low_phase_highs", h, 0);
    @(negedge clk);
    #1;
    check_output("first_rise", int'(cpu_clk_rise), 1);
    measure(8, h, r);
    check_output("div3_highs_per_period", h, 4);
    check_output("div3_rises_per_period", r, 1);
    measure(16, h, r);
    check_output("div3_highs_two_periods", h, 8);
    check_output("div3_rises_two_periods", r, 2);

    // div=0 toggles every clk; then lower div 9->2 while high.
    #1 div = 16'd0;
    repeat (8) @(negedge clk);
    measure(10, h, r);
    check_output("div0_highs", h, 5);
    check_output("div0_rises", r, 5);
    #1 div = 16'd9;
    wait_rise(30, found);
    check_output("div9_rise_seen", int'(found), 1);
    repeat (4) @(negedge clk);
    #1;
    check_output("div9_still_high", int'(cpu_clk), 1);
    #1 div = 16'd2;
    @(negedge clk);
    #1;
    check_output("div_lowered_ends_phase", int'(cpu_clk), 0);

    // Manual mode: bouncy press held long gives exactly one 2-clk pulse.
    #1 manual_mode = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    check_output("manual_idle_low", int'(cpu_clk), 0);
    apply_stimulus(64'h3F_FFFD, 40, h, r);
    check_output("step_highs", h, SH);
    check_output("step_rises", r, 1);

    // Bounce shorter than the debounce window never steps.
    apply_stimulus(64'h1D7, 30, h, r);
    check_output("short_bounce_highs", h, 0);
    check_output("short_bounce_rises", r, 0);

    // A press made during HLT is discarded.
    halt = 1'b1;
    apply_stimulus(64'hFFF, 25, h, r);
    halt = 1'b0;
    measure(10, h, r);
    check_output("halt_press_discarded", h, 0);

    // Run mode, HLT raised in the first high cycle: phase completes, then low.
    manual_mode = 1'b0;
    div = 16'd3;
    wait_rise(40, found);
    check_output("halt_test_rise_seen", int'(found), 1);
    #1 halt = 1'b1;
    measure(12, h, r);
    check_output("halt_phase_completes", h, 3);
    check_output("halt_no_rise", r, 0);
    check_output("halt_holds_low", int'(cpu_clk), 0);
    #1 halt = 1'b0;
    wait_rise(4, found);
    check_output("halt_release_rise", int'(found), 1);

    // Reset in the first high cycle drops the clock immediately.
    #1 clr = 1'b1;
    #1;
    check_output("async_clr_cpu_clk", int'(cpu_clk), 0);
    check_output("async_clr_cpu_clk_n", int'(cpu_clk_n), 1);
    check_output("async_clr_rise", int'(cpu_clk_rise), 0);
    repeat (2) @(negedge clk);
    #2 clr = 1'b0;
    measure(3, h, r);
    check_output("post_clr_low_phase", h, 0);
    @(negedge clk);
    #1;
    check_output("post_clr_first_rise", int'(cpu_clk_rise), 1);
    measure(16, h, r);
    check_output("post_clr_highs", h, 8);
    check_output("post_clr_rises", r, 2);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
